time_disp_scan: RTL
===================

Name: time_disp_scan

Overview:
- Downstream consumer of the binary sec/min/hr timekeeping counters.
- Converts sec (0-59), min (0-59) and hr (0-23) into six decimal digits.
- Drives a multiplexed 6-digit common-anode 7-segment display: one digit active at a time, rotating at a programmable rate.
- Samples its inputs once per scan frame, so a carry ripple (e.g. 23:59:59 -> 00:00:00) never shows as a half-updated frame.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays lit; legal range >= 2.
- CW, $clog2(SCAN_DIV): width of the scan prescaler; derived, not overridden.

Ports:
- clk      input   1  system clock
- rst_n    input   1  synchronous, active-low reset
- sec      input   6  seconds, binary, 0-59
- min      input   6  minutes, binary, 0-59
- hr       input   5  hours, binary, 0-23
- seg      output  7  segments {g,f,e,d,c,b,a}, active-high
- dp       output  1  decimal point of the active digit, active-high
- dig_sel  output  6  digit enables, one-hot, active-low; bit k = digit k
- frame    output  1  one-cycle pulse, high on the cycle digit 0 is first driven in a frame

Behaviour:
- One clock (clk). Reset is synchronous, active-low on rst_n, sampled on the rising edge of clk.
- State registers:
  - scan_cnt[CW-1:0]
  - idx[2:0], range 0-5
  - snapshot registers s_sec, s_min, s_hr
- Reset values:
  - scan_cnt = 0, idx = 0, snapshot = 0.
  - Outputs: seg = 0, dp = 0, dig_sel = 6'b111111 (all off), frame = 0.
- Scan prescaler:
  - scan_cnt increments every cycle and wraps from SCAN_DIV-1 to 0.
  - On that wrap, idx advances 0->1->...->5->0.
  - One frame = 6*SCAN_DIV cycles.
- Snapshot:
  - s_* load sec/min/hr on the frame-end cycle (scan_cnt == SCAN_DIV-1 and idx == 5).
  - s_* hold otherwise. Input changes mid-frame are invisible until the next frame.
- Digit mapping:
  - idx 0 = s_sec % 10, idx 1 = s_sec / 10
  - idx 2 = s_min % 10, idx 3 = s_min / 10
  - idx 4 = s_hr % 10, idx 5 = s_hr / 10
- Out-of-range inputs:
  - sec/min up to 63 and hr up to 31 are not clamped.
  - They display arithmetically, e.g. sec = 63 shows "63".
- Division: by constant 10 on a 6-bit value. Implemented as a 64-entry case/lookup or a multiply-shift; no iterative divider.
- Segment encoding, standard: 0 = 7'h3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- dp: high when idx is 2 or 4 (separators hh.mm.ss); low otherwise.
- Latency:
  - All outputs are registered from (idx, snapshot) with 1 cycle latency.
  - Outputs on cycle t+1 reflect idx/snapshot at cycle t.
  - frame is high on the cycle dig_sel first becomes 6'b111110 in a frame.
- First cycle after rst_n rises:
  - Outputs are dig_sel = 111110, seg = 7'h3F, dp = 0, frame = 1.
  - From reset, the first frame shows 00.00.00.
- Reset mid-operation: state and outputs return to the reset values on the next edge; the scan restarts from digit 0.
- dig_sel is always exactly one low bit except while in reset.

Optional Feature:
- Macro: COLON_BLINK_EN.
- Defined: dp on idx 2 and 4 is gated by ~s_sec[0], so the separators light on even seconds and are dark on odd seconds.
- Not defined: separators are lit every frame.
- All other behaviour is identical in both builds.

Test Plan:
- Reset release, SCAN_DIV = 4, inputs 0 -> seg = 3F on every digit; dig_sel steps 111110 -> 111101 -> ... -> 011111, each for 4 cycles; frame pulses every 24 cycles.
- sec = 37, min = 5, hr = 23 applied before frame end -> next frame seg per digit 0-5 = 07, 4F, 6D, 3F, 4F, 5B; dp high on digits 2 and 4 only.
- Change sec from 12 to 13 mid-frame (at digit 2) -> digit 0 of the remainder of the frame still 5B; the next frame shows 4F.
- Wrap 23:59:59 -> 00:00:00 straddling the frame-end cycle -> every frame shows a coherent time; no mixed digits.
- Assert rst_n = 0 while idx = 3 -> next edge: dig_sel = 111111, seg = 0, dp = 0; after release, the scan restarts at digit 0 with frame = 1.
- COLON_BLINK_EN build, sec = 4 then sec = 5 -> dp is lit on digits 2 and 4 in the frame showing 4 and dark in the frame showing 5.

Source files
------------

// File: rtl/time_disp_scan.sv
// Multiplexed 6-digit 7-segment time display (hh.mm.ss) with once-per-frame input snapshot.
// Define COLON_BLINK_EN to blink the separators on odd seconds.
module time_disp_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel,
    output logic       frame
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [5:0]    s_sec;
    logic [5:0]    s_min;
    logic [4:0]    s_hr;

    logic       scan_wrap;
    logic       frame_end;
    logic       frame_start;
    logic [3:0] digit;
    logic       dp_next;

    // Tens digit via a compare chain; inputs never exceed 63 so 6 is the top value.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return 4'(v - 6'(tens_of(v)) * 6'd10);
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign scan_wrap   = (scan_cnt == CW'(SCAN_DIV - 1));
    assign frame_end   = scan_wrap && (idx == 3'd5);
    assign frame_start = (scan_cnt == '0) && (idx == 3'd0);

    always_comb begin
        digit   = 4'd0;
        dp_next = 1'b0;
        case (idx)
            3'd0: digit = ones_of(s_sec);
            3'd1: digit = tens_of(s_sec);
            3'd2: digit = ones_of(s_min);
            3'd3: digit = tens_of(s_min);
            3'd4: digit = ones_of({1'b0, s_hr});
            3'd5: digit = tens_of({1'b0, s_hr});
            default: digit = 4'd0;
        endcase
`ifdef COLON_BLINK_EN
        dp_next = ((idx == 3'd2) || (idx == 3'd4)) && !s_sec[0];
`else
        dp_next = (idx == 3'd2) || (idx == 3'd4);
`endif
    end

    // Outputs lag (idx, snapshot) by one cycle, so frame lines up with digit 0 appearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            s_sec    <= 6'd0;
            s_min    <= 6'd0;
            s_hr     <= 5'd0;
            seg      <= 7'h00;
            dp       <= 1'b0;
            dig_sel  <= 6'b111111;
            frame    <= 1'b0;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            if (frame_end) begin
                s_sec <= sec;
                s_min <= min;
                s_hr  <= hr;
            end
            seg     <= seg_of(digit);
            dp      <= dp_next;
            dig_sel <= ~(6'd1 << idx);
            frame   <= frame_start;
        end
    end

endmodule
